// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave with an auto-incrementing register file.
// All SPI pins are oversampled in the clk domain. The first word of a frame is
// a command (MSB = write, low bits = start address); the following words are
// burst data written to, or read from, consecutive registers.
module spi_reg_slave #(
    parameter int WORD_W      = 8,
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               SCLK,
    input  logic                               SSEL,
    input  logic                               MOSI,
    output logic                               MISO,
    output logic [NUM_REGS*WORD_W-1:0]         regs_o,
    output logic                               wr_stb,
    output logic [$clog2(NUM_REGS)-1:0]        wr_addr,
    output logic                               xfer_done
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ssel_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_prev_reg;
    logic                   ssel_prev_reg;

    state_t                 state_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [WORD_W-2:0]      rx_reg;
    logic [WORD_W-1:0]      tx_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [WORD_W-1:0]      regs_mem [NUM_REGS];
    logic                   wr_stb_reg;
    logic [ADDR_W-1:0]      wr_addr_reg;
    logic                   xfer_done_reg;

    logic                   sclk_s;
    logic                   ssel_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ssel_rise;
    logic [WORD_W-1:0]      word_next;

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign ssel_rise = ssel_s & ~ssel_prev_reg;
    // Word as it stands once the current rise's bit is shifted in
    assign word_next = {rx_reg, mosi_s};

    // Synchronise the SPI pins and keep one extra sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            ssel_sync_reg <= '0;
            mosi_sync_reg <= '0;
            sclk_prev_reg <= 1'b0;
            ssel_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            ssel_sync_reg <= {ssel_sync_reg[SYNC_STAGES-2:0], SSEL};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            sclk_prev_reg <= sclk_s;
            ssel_prev_reg <= ssel_s;
        end
    end

    // Frame FSM, shift registers, register file and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            addr_reg      <= '0;
            wr_stb_reg    <= 1'b0;
            wr_addr_reg   <= '0;
            xfer_done_reg <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_mem[i] <= '0;
            end
        end else begin
            wr_stb_reg    <= 1'b0;
            xfer_done_reg <= 1'b0;
            if (!ssel_s) begin
                // Deselect overrides any SCLK edge seen in the same cycle;
                // a partial word is simply dropped with the counters.
                if (state_reg != IDLE) begin
                    xfer_done_reg <= 1'b1;
                end
                state_reg   <= IDLE;
                bit_cnt_reg <= '0;
                rx_reg      <= '0;
                tx_reg      <= '0;
            end else if (state_reg == IDLE) begin
                // A coincident SCLK rise is ignored; counting starts clean
                if (ssel_rise) begin
                    state_reg   <= CMD;
                    bit_cnt_reg <= '0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_reg <= word_next[WORD_W-2:0];
                    if (bit_cnt_reg == CNT_LAST) begin
                        bit_cnt_reg <= '0;
                        case (state_reg)
                            CMD: begin
                                addr_reg  <= word_next[ADDR_W-1:0];
                                state_reg <= word_next[WORD_W-1] ? WDATA : RDATA;
                            end
                            WDATA: begin
                                regs_mem[addr_reg] <= word_next;
                                wr_stb_reg         <= 1'b1;
                                wr_addr_reg        <= addr_reg;
                                addr_reg           <= addr_reg + 1'b1;
                            end
                            RDATA: begin
                                addr_reg <= addr_reg + 1'b1;
                            end
                            default: begin
                                state_reg <= IDLE;
                            end
                        endcase
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                // Reload at a word boundary so the MSB is ready before the next rise
                if (sclk_fall) begin
                    if (bit_cnt_reg == '0) begin
                        tx_reg <= regs_mem[addr_reg];
                    end else begin
                        tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_o[gi*WORD_W +: WORD_W] = regs_mem[gi];
        end
    endgenerate

    assign MISO      = (state_reg == RDATA) & tx_reg[WORD_W-1];
    assign wr_stb    = wr_stb_reg;
    assign wr_addr   = wr_addr_reg;
    assign xfer_done = xfer_done_reg;

endmodule
